// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C SCL generator: FSM state encoding, the
// smallest legal half-period and the default divider width.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW     = 2'd1,
    RELEASE = 2'd2,
    HIGH    = 2'd3
  } scl_state_e;

  // A half-period shorter than this would make the mid strobe collide
  // with the edge strobe, so shorter requests are raised to it.
  localparam int unsigned MIN_DIV = 2;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/i2c_phase_counter.sv
// Phase timer shared by the SCL low and high phases. A start loads the
// clamped phase length and restarts the count at 0; each step advances it.
//
// Ports:
//   clk_i       core clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     begin a new phase (count <- 0, length <- max(len_i, MIN_DIV))
//   step_i      advance the count by one
//   len_i       requested phase length in core cycles
//   mid_next_o  the count after the next step equals length/2
//   last_o      the current cycle is the last cycle of the phase
module i2c_phase_counter
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 step_i,
  input  logic [DIV_WIDTH-1:0] len_i,
  output logic                 mid_next_o,
  output logic                 last_o
);

  localparam logic [DIV_WIDTH-1:0] MIN_LEN = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] len_q, len_d;
  logic [DIV_WIDTH-1:0] cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + ONE;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (start_i) begin
      cnt_d = '0;
      len_d = (len_i < MIN_LEN) ? MIN_LEN : len_i;
    end else if (step_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  // Looking one count ahead lets the owner register the mid strobe so it
  // is visible in exactly the cycle where the count equals length/2.
  assign mid_next_o = (cnt_inc == (len_q >> 1));
  assign last_o     = (cnt_q == (len_q - ONE));

endmodule

// File: rtl/i2c_scl_generator.sv
// Programmable SCL generator for the I2C master. Produces SCL with a
// runtime half-period divider, gates enable only on period boundaries,
// honours slave clock stretching with an optional timeout and emits
// single-cycle phase strobes for the bit controller.
//
// Ports:
//   i2c_core_clk_i  core clock, rising edge
//   i2c_core_rst_i  synchronous active-high reset
//   clk_en_i        request SCL toggling (sampled in IDLE and at end of HIGH)
//   div_i           half-period in core cycles (values below 2 act as 2)
//   scl_i           synchronised bus SCL level
//   i2c_scl_o       SCL drive, 0 = pull low, 1 = release
//   scl_fall_o      first cycle SCL is driven low
//   scl_low_mid_o   middle of the low phase (SDA change point)
//   scl_rise_o      first cycle after SCL is seen high following release
//   scl_high_mid_o  middle of the high phase (SDA sample point)
//   busy_o          state is not IDLE
//   stretch_o       a slave is holding SCL low after release
//   timeout_o       stretching exceeded STRETCH_TIMEOUT cycles
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | SCL released, waiting for clk_en_i
// LOW     | SCL driven low for div_q cycles
// RELEASE | SCL released, waiting for the bus to actually go high
// HIGH    | SCL high for div_q cycles, then next period or IDLE
module i2c_scl_generator
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int unsigned TO_WIDTH        = 16,
  parameter int unsigned STRETCH_TIMEOUT = 1000
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 i2c_core_rst_i,
  input  logic                 clk_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 scl_i,
  output logic                 i2c_scl_o,
  output logic                 scl_fall_o,
  output logic                 scl_low_mid_o,
  output logic                 scl_rise_o,
  output logic                 scl_high_mid_o,
  output logic                 busy_o,
  output logic                 stretch_o,
  output logic                 timeout_o
);

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(STRETCH_TIMEOUT);
  localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);
  localparam logic                TO_EN    = (STRETCH_TIMEOUT != 0);

  scl_state_e state_q;

  logic scl_q;
  logic fall_q;
  logic low_mid_q;
  logic rise_q;
  logic high_mid_q;
  logic busy_q;
  logic stretch_q;
  logic timeout_q;

  logic [TO_WIDTH-1:0] stretch_cnt_q, stretch_cnt_d;
  logic                to_hit;

  logic pc_start;
  logic pc_step;
  logic pc_mid_next;
  logic pc_last;

  i2c_phase_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_phase_counter (
    .clk_i      (i2c_core_clk_i),
    .rst_i      (i2c_core_rst_i),
    .start_i    (pc_start),
    .step_i     (pc_step),
    .len_i      (div_i),
    .mid_next_o (pc_mid_next),
    .last_o     (pc_last)
  );

  always_comb begin
    pc_start = 1'b0;
    pc_step  = 1'b0;
    case (state_q)
      IDLE:    pc_start = clk_en_i;
      LOW:     pc_step  = !pc_last;
      RELEASE: pc_start = scl_i;
      HIGH: begin
        pc_step  = !pc_last;
        pc_start = pc_last && clk_en_i;
      end
      default: ;
    endcase

    // Saturate so a disabled timeout never wraps back through the limit.
    stretch_cnt_d = (stretch_cnt_q == '1) ? stretch_cnt_q : stretch_cnt_q + TO_ONE;
    to_hit        = TO_EN && (stretch_cnt_d == TO_LIMIT);
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      state_q       <= IDLE;
      scl_q         <= 1'b1;
      fall_q        <= 1'b0;
      low_mid_q     <= 1'b0;
      rise_q        <= 1'b0;
      high_mid_q    <= 1'b0;
      busy_q        <= 1'b0;
      stretch_q     <= 1'b0;
      timeout_q     <= 1'b0;
      stretch_cnt_q <= '0;
    end else begin
      fall_q     <= 1'b0;
      low_mid_q  <= 1'b0;
      rise_q     <= 1'b0;
      high_mid_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          scl_q     <= 1'b1;
          stretch_q <= 1'b0;
          if (clk_en_i) begin
            state_q <= LOW;
            scl_q   <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        LOW: begin
          if (pc_last) begin
            state_q <= RELEASE;
            scl_q   <= 1'b1;
          end else begin
            low_mid_q <= pc_mid_next;
          end
        end
        RELEASE: begin
          if (scl_i) begin
            state_q       <= HIGH;
            rise_q        <= 1'b1;
            stretch_q     <= 1'b0;
            stretch_cnt_q <= '0;
          end else if (to_hit) begin
            // SCL output is already released, so abandoning the period
            // leaves the bus undriven.
            state_q       <= IDLE;
            timeout_q     <= 1'b1;
            stretch_q     <= 1'b0;
            busy_q        <= 1'b0;
            stretch_cnt_q <= '0;
          end else begin
            stretch_q     <= 1'b1;
            stretch_cnt_q <= stretch_cnt_d;
          end
        end
        HIGH: begin
          if (pc_last) begin
            if (clk_en_i) begin
              state_q <= LOW;
              scl_q   <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            high_mid_q <= pc_mid_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i2c_scl_o      = scl_q;
  assign scl_fall_o     = fall_q;
  assign scl_low_mid_o  = low_mid_q;
  assign scl_rise_o     = rise_q;
  assign scl_high_mid_o = high_mid_q;
  assign busy_o         = busy_q;
  assign stretch_o      = stretch_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Directed bench for i2c_scl_generator. Observed outputs are packed as
// {scl, fall, low_mid, rise, high_mid, busy, stretch, timeout}.
module tb_i2c_scl_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] div = 16'd4;
  logic        scl_i;

  logic scl_o, fall, lmid, rise, hmid, busy, stretch, tout;

  int n_checks = 0;
  int n_pass   = 0;
  int high_cnt;

  localparam logic [7:0] IDLE_V = 8'b1000_0000;
  localparam logic [7:0] FALL_V = 8'b0100_0100;

  // Slave model: it can only hold the line low, never drive it high.
  assign scl_i = scl_o & ~hold;

  always #5 clk = ~clk;

  i2c_scl_generator #(
    .DIV_WIDTH       (16),
    .TO_WIDTH        (16),
    .STRETCH_TIMEOUT (20)
  ) dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_i (rst),
    .clk_en_i       (clk_en),
    .div_i          (div),
    .scl_i          (scl_i),
    .i2c_scl_o      (scl_o),
    .scl_fall_o     (fall),
    .scl_low_mid_o  (lmid),
    .scl_rise_o     (rise),
    .scl_high_mid_o (hmid),
    .busy_o         (busy),
    .stretch_o      (stretch),
    .timeout_o      (tout)
  );

  function automatic logic [7:0] obs();
    return {scl_o, fall, lmid, rise, hmid, busy, stretch, tout};
  endfunction

  // Unstretched continuous toggling: period 2*d+1, low cycles 0..d-1,
  // release at d, high d+1..2d. After cycle last_k the block sits idle.
  function automatic logic [7:0] pat(int k, int d, int last_k);
    int p;
    if (k > last_k) return IDLE_V;
    p = k % (2 * d + 1);
    return {p >= d, p == 0, p == d / 2, p == d + 1, p == d + 1 + d / 2,
            1'b1, 1'b0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int idx, logic [7:0] o, logic [7:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s[%0d]: observed %b required %b", tag, idx, o, e);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset", 0, obs(), IDLE_V);
    rst = 1'b0;
    tick();
    chk("idle_no_en", 0, obs(), IDLE_V);

    // div=4 continuous, then drop enable two cycles into a low phase
    clk_en = 1'b1;
    tick();
    chk("first_fall", 0, obs(), FALL_V);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("div4_run", k, obs(), pat(k, 4, 44));
      if (k == 38) clk_en = 1'b0;
    end

    // Slave stretches the first high phase by 10 cycles
    hold   = 1'b1;
    clk_en = 1'b1;
    tick();
    chk("stretch", 0, obs(), FALL_V);
    clk_en   = 1'b0;
    high_cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("stretch", j, obs(),
          {j >= 4, 1'b0, j == 2, j == 15, j == 17, j <= 18, (j >= 5) && (j <= 14), 1'b0});
      if (scl_o && busy) high_cnt++;
      if (j == 14) hold = 1'b0;
    end
    n_checks++;
    assert (high_cnt == 15) n_pass++;
    else $error("FAIL stretch_high_len: observed %0d required 15", high_cnt);

    // SCL stuck low until the timeout fires
    hold   = 1'b1;
    clk_en = 1'b1;
    tick();
    chk("timeout", 0, obs(), FALL_V);
    clk_en = 1'b0;
    for (int j = 1; j <= 28; j++) begin
      tick();
      chk("timeout", j, obs(),
          {j >= 4, 1'b0, j == 2, 1'b0, 1'b0, j <= 23, (j >= 5) && (j <= 23), j == 24});
    end
    hold = 1'b0;

    // div_i 4 -> 8 during the low phase: low stays 4, high becomes 8
    clk_en = 1'b1;
    tick();
    chk("div_change", 0, obs(), FALL_V);
    div    = 16'd8;
    clk_en = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      chk("div_change", j, obs(),
          {j >= 4, 1'b0, j == 2, j == 5, j == 9, j <= 12, 1'b0, 1'b0});
    end

    // div_i=0 behaves as div=2, period 5
    div    = 16'd0;
    clk_en = 1'b1;
    tick();
    chk("div0", 0, obs(), pat(0, 2, 9));
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("div0", k, obs(), pat(k, 2, 9));
      if (k == 6) clk_en = 1'b0;
    end

    // Reset pulse in the middle of a high phase, then re-enable
    div    = 16'd4;
    clk_en = 1'b1;
    tick();
    chk("rst_mid", 0, obs(), pat(0, 4, 8));
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("rst_mid", j, obs(), pat(j, 4, 8));
    end
    rst    = 1'b1;
    clk_en = 1'b0;
    tick();
    chk("rst_mid", 7, obs(), IDLE_V);
    rst = 1'b0;
    tick();
    chk("rst_mid", 8, obs(), IDLE_V);
    clk_en = 1'b1;
    tick();
    chk("rst_mid", 9, obs(), FALL_V);
    clk_en = 1'b0;
    for (int j = 10; j <= 19; j++) begin
      tick();
      chk("rst_mid", j, obs(), pat(j - 9, 4, 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
